// File: rtl/pal_cfg_loader_if.sv
// Byte-stream handshake between the configuration source and pal_cfg_loader.
// The master drives start and the data bytes. The loader, as slave, answers with byte_ready.
interface pal_cfg_loader_if;
  logic       start;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output start, output byte_in, output byte_valid, input byte_ready);
  modport slave  (input start, input byte_in, input byte_valid, output byte_ready);
endinterface

// File: rtl/pal_cfg_loader.sv
// pal_cfg_loader: takes config bytes over a valid/ready handshake and shifts them LSB-first into the PAL chain.
// The PAL is held disabled until the chain is full. Define PAL_CFG_CHECKSUM_EN to add a trailing XOR checksum byte.
module pal_cfg_loader #(
  parameter int NUM_INPUTS        = 8,
  parameter int NUM_OUTPUTS       = 8,
  parameter int NUM_INTERM_STAGES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  pal_cfg_loader_if.slave   host,
  output logic              cfg_bit,
  output logic              cfg_shift_en,
  output logic              pal_enable,
  output logic              busy,
  output logic              cfg_done,
  output logic              cfg_err
);

  // The chain length must be a whole number of bytes, because byte completion is detected on bitcnt[2:0].
  localparam int BITSTREAM_LEN = 2 * NUM_INPUTS * NUM_INTERM_STAGES + NUM_INTERM_STAGES * NUM_OUTPUTS;
  localparam int CNT_W         = $clog2(BITSTREAM_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_BIT_IDX = CNT_W'(BITSTREAM_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

`ifdef PAL_CFG_CHECKSUM_EN
  localparam state_t AFTER_CHAIN = S_CHECK;
`else
  localparam state_t AFTER_CHAIN = S_DONE;
`endif

  state_t           state;
  state_t           next_state;
  logic [7:0]       shreg;
  logic [CNT_W-1:0] bitcnt;
  logic             ready_q;
  logic             shift_q;
  logic             busy_q;
  logic             done_q;
  logic             accept;
  logic             byte_end;
  logic             restart;

  assign accept   = host.byte_valid & ready_q;
  assign byte_end = (bitcnt[2:0] == 3'd7);
  assign restart  = host.start && (state inside {S_IDLE, S_DONE, S_ERROR});

`ifdef PAL_CFG_CHECKSUM_EN
  logic [7:0] checksum;
  logic       err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (restart) begin
      checksum <= '0;
    end else if (state == S_LOAD && accept) begin
      checksum <= checksum ^ host.byte_in;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    // NOTE: default assigned before the case so every path drives next_state and no latch is inferred.
    next_state = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (host.start) next_state = S_LOAD;
      S_LOAD:                  if (accept) next_state = S_SHIFT;
      S_SHIFT: begin
        if (byte_end) next_state = (bitcnt == LAST_BIT_IDX) ? AFTER_CHAIN : S_LOAD;
      end
`ifdef PAL_CFG_CHECKSUM_EN
      S_CHECK: if (accept) next_state = (host.byte_in == checksum) ? S_DONE : S_ERROR;
`endif
      default: next_state = S_IDLE;
    endcase
  end

  // In SHIFT, bitcnt[2:0] counts the 8 shift cycles of the current byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg  <= '0;
      bitcnt <= '0;
    end else if (restart) begin
      bitcnt <= '0;
    end else if (state == S_SHIFT) begin
      shreg  <= shreg >> 1;
      bitcnt <= bitcnt + CNT_W'(1);
    end else if (state == S_LOAD && accept) begin
      shreg  <= host.byte_in;
    end
  end

  // The outputs are registered from next_state, so they change on the same edge as the state and never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      shift_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ready_q <= (next_state == S_LOAD) || (next_state == S_CHECK);
      shift_q <= (next_state == S_SHIFT);
      busy_q  <= next_state inside {S_LOAD, S_SHIFT, S_CHECK};
      done_q  <= (next_state == S_DONE);
    end
  end

`ifdef PAL_CFG_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= (next_state == S_ERROR);
  end
  assign cfg_err = err_q;
`else
  assign cfg_err = 1'b0;
`endif

  assign host.byte_ready = ready_q;
  assign cfg_shift_en    = shift_q;
  assign cfg_bit         = shift_q & shreg[0];
  assign pal_enable      = done_q;
  assign cfg_done        = done_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Randomised bench for pal_cfg_loader. A byte/bit-queue model is checked against the DUT on every negedge.
// Literal checks pin the model: bit positions, the 0xA5 sequence, cycle counts and the status flags.
module tb_pal_cfg_loader;

  localparam int NBYTES = 48;
  localparam int NBITS  = NBYTES * 8;
`ifdef PAL_CFG_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic cfg_bit, cfg_shift_en, pal_enable, busy, cfg_done, cfg_err;

  pal_cfg_loader_if host ();

  pal_cfg_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .host         (host),
    .cfg_bit      (cfg_bit),
    .cfg_shift_en (cfg_shift_en),
    .pal_enable   (pal_enable),
    .busy         (busy),
    .cfg_done     (cfg_done),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending serial bits plus counters of bytes and shifts
  bit         m_active, m_done, m_err;
  int         m_shift_left, m_bytes;
  logic [7:0] m_sum;
  bit         m_q[$];

  // Observed chain traffic, logged for the literal checks
  bit         shift_log[$];
  int         busy_cnt = 0;

  always @(negedge clk) begin
    logic [6:0] act_v, exp_v;
    act_v = {host.byte_ready, cfg_shift_en, cfg_bit, busy, pal_enable, cfg_done, cfg_err};
    if (!rst_n) begin
      check("reset_outputs", 32'(act_v), 32'd0);
      m_active = 0; m_done = 0; m_err = 0; m_shift_left = 0; m_bytes = 0; m_sum = 0;
      m_q.delete();
    end else begin
      exp_v = {m_active && (m_shift_left == 0), m_shift_left > 0,
               (m_shift_left > 0) ? m_q[0] : 1'b0, m_active, m_done, m_done, m_err};
      check("cycle_outputs", 32'(act_v), 32'(exp_v));
      if (cfg_shift_en) shift_log.push_back(cfg_bit);
      if (busy) busy_cnt++;
      // Predict the effect of the coming edge from the inputs now applied.
      if (m_active) begin
        if (m_shift_left > 0) begin
          void'(m_q.pop_front());
          m_shift_left--;
          if (m_shift_left == 0 && m_bytes == NBYTES && !CHK) begin
            m_active = 0;
            m_done   = 1;
          end
        end else if (host.byte_valid) begin
          if (m_bytes < NBYTES) begin
            for (int j = 0; j < 8; j++) m_q.push_back(host.byte_in[j]);
            m_sum        = m_sum ^ host.byte_in;
            m_bytes      = m_bytes + 1;
            m_shift_left = 8;
          end else begin
            m_active = 0;
            if (host.byte_in == m_sum) m_done = 1;
            else                       m_err  = 1;
          end
        end
      end else if (host.start) begin
        m_active = 1; m_bytes = 0; m_sum = 0; m_done = 0; m_err = 0;
        m_q.delete();
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] img [NBYTES];
  int base_shift, base_busy;

  task automatic mark();
    base_shift = shift_log.size();
    base_busy  = busy_cnt;
  endtask

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic pulse_start();
    host.start = 1'b1;
    @(posedge clk); #1;
    host.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 0;
    host.byte_in    = b;
    host.byte_valid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      ok = host.byte_ready;
      @(posedge clk); #1;
    end
    check("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = !busy;
    end
    check("idle_timeout", 32'(ok), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_load(input bit do_start, input bit gaps, input int mid_start_at, input bit bad_sum);
    logic [7:0] s = '0;
    if (do_start) pulse_start();
    for (int i = 0; i < NBYTES; i++) begin
      send_byte(img[i]);
      s = s ^ img[i];
      if (i == mid_start_at) pulse_start();
      if (gaps && $urandom_range(0, 3) == 0) begin
        host.byte_valid = 1'b0;
        host.byte_in    = 8'($urandom);
        repeat ($urandom_range(1, 12)) begin @(posedge clk); #1; end
      end
    end
    if (CHK) send_byte(bad_sum ? (s ^ 8'h01) : s);
    host.byte_valid = 1'b0;
    host.byte_in    = '0;
    wait_idle();
  endtask

  task automatic randomize_img();
    for (int i = 0; i < NBYTES; i++) img[i] = 8'($urandom);
  endtask

  initial begin
    int n_ones, p0, p1;
    logic [7:0] f8;
    host.start = 1'b0; host.byte_in = '0; host.byte_valid = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'({host.byte_ready, cfg_shift_en, cfg_bit, busy, pal_enable, cfg_done, cfg_err}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Test 1: all bytes zero except byte 4 = 0x03, with no gaps
    for (int i = 0; i < NBYTES; i++) img[i] = 8'h00;
    img[4] = 8'h03;
    mark();
    send_load(1, 0, -1, 0);
    check("t1_shift_count", 32'(shift_log.size() - base_shift), 32'(NBITS));
    n_ones = 0; p0 = -1; p1 = -1;
    for (int k = base_shift; k < shift_log.size(); k++) begin
      if (shift_log[k]) begin
        if (n_ones == 0) p0 = k - base_shift;
        if (n_ones == 1) p1 = k - base_shift;
        n_ones++;
      end
    end
    check("t1_ones_count", 32'(n_ones), 32'd2);
    check("t1_one_pos_a", 32'(p0), 32'd32);
    check("t1_one_pos_b", 32'(p1), 32'd33);
    check("t1_busy_cycles", 32'(busy_cnt - base_busy), 32'(432 + (CHK ? 1 : 0)));
    check("t1_pal_enable", 32'(pal_enable), 32'd1);

    // Test 2: first byte 0xA5 goes out as 1,0,1,0,0,1,0,1
    randomize_img();
    img[0] = 8'hA5;
    mark();
    send_load(1, 1, -1, 0);
    for (int j = 0; j < 8; j++) f8[j] = shift_log[base_shift + j];
    check("t2_a5_sequence", 32'(f8), 32'h0000_00A5);
    check("t2_shift_count", 32'(shift_log.size() - base_shift), 32'(NBITS));

    // Test 3: random data, with byte_valid held through SHIFT and random gaps
    for (int r = 0; r < 2; r++) begin
      randomize_img();
      mark();
      send_load(1, 1, -1, 0);
      check("t3_shift_count", 32'(shift_log.size() - base_shift), 32'(NBITS));
      check("t3_cfg_done", 32'(cfg_done), 32'd1);
    end

    // Test 4: reset after byte 20, then a full reload
    randomize_img();
    pulse_start();
    for (int i = 0; i <= 20; i++) send_byte(img[i]);
    host.byte_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t4_reset_mid_load",
          32'({host.byte_ready, cfg_shift_en, cfg_bit, busy, pal_enable, cfg_done, cfg_err}), 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    @(posedge clk); #1;
    randomize_img();
    mark();
    send_load(1, 1, -1, 0);
    check("t4_shift_count", 32'(shift_log.size() - base_shift), 32'(NBITS));
    check("t4_cfg_done", 32'(cfg_done), 32'd1);

    // Test 5: start during SHIFT is ignored; start in DONE drops pal_enable
    randomize_img();
    mark();
    send_load(1, 0, 5, 0);
    check("t5_shift_count", 32'(shift_log.size() - base_shift), 32'(NBITS));
    check("t5_pal_enable", 32'(pal_enable), 32'd1);
    pulse_start();
    @(negedge clk);
    check("t5_enable_drops", 32'({pal_enable, cfg_done}), 32'd0);
    @(posedge clk); #1;
    randomize_img();
    mark();
    send_load(0, 1, -1, 0);
    check("t5_reload_enable", 32'(pal_enable), 32'd1);

`ifdef PAL_CFG_CHECKSUM_EN
    // Test 6: a corrupted checksum byte -> error; a restart with the correct byte -> done
    randomize_img();
    send_load(1, 1, -1, 1);
    check("t6_err_flags", 32'({cfg_err, pal_enable, cfg_done}), 32'b100);
    randomize_img();
    send_load(1, 0, -1, 0);
    check("t6_ok_flags", 32'({cfg_err, pal_enable, cfg_done}), 32'b011);
`endif

    repeat (3) begin @(posedge clk); #1; end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
